// File: rtl/sd_block_streamer_pkg.sv
// sd_block_streamer_pkg: shared constants, fill-state encoding and skid entry layout
// for the SD block streamer.
package sd_block_streamer_pkg;

    localparam int BLK_BYTES = 512;
    localparam int IDX_W     = 9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_INIT,
        S_REQ,
        S_FILL,
        S_NEXT,
        S_FLUSH
    } fill_state_t;

    typedef struct packed {
        logic       bank;
        logic       last;
        logic [7:0] data;
    } skid_ent_t;

endpackage

// File: rtl/sd_pingpong_buf.sv
// sd_pingpong_buf: two 512-byte single-port banks with per-bank full flags,
// one write port and one registered read port.
module sd_spram #(
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            else    rdata     <= mem[addr];
        end
    end
endmodule

module sd_pingpong_buf
    import sd_block_streamer_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic             wr_bank,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [7:0]       wr_data,
    input  logic             set_full,
    input  logic             set_bank,
    input  logic             clr_full,
    input  logic             clr_bank,
    input  logic             rd_en,
    input  logic             rd_bank,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [7:0]       rd_data,
    output logic [1:0]       full
);
    logic [1:0] full_q, full_d;
    logic       rd_bank_q, rd_bank_d;
    logic [1:0] we, en;
    logic [7:0] q0, q1;

    // Fill only targets an empty bank and drain only reads a full one, so the
    // two ports never collide on the same bank.
    assign we = {wr_en && wr_bank, wr_en && !wr_bank};
    assign en = we | {rd_en && rd_bank, rd_en && !rd_bank};

    sd_spram #(.DEPTH(BLK_BYTES), .AW(IDX_W)) u_bank0 (
        .clk(clk), .en(en[0]), .we(we[0]),
        .addr(we[0] ? wr_idx : rd_idx), .wdata(wr_data), .rdata(q0)
    );

    sd_spram #(.DEPTH(BLK_BYTES), .AW(IDX_W)) u_bank1 (
        .clk(clk), .en(en[1]), .we(we[1]),
        .addr(we[1] ? wr_idx : rd_idx), .wdata(wr_data), .rdata(q1)
    );

    always_comb begin
        full_d    = full_q;
        rd_bank_d = rd_en ? rd_bank : rd_bank_q;
        if (set_full) full_d[set_bank] = 1'b1;
        if (clr_full) full_d[clr_bank] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            full_q    <= 2'b00;
            rd_bank_q <= 1'b0;
        end else begin
            full_q    <= full_d;
            rd_bank_q <= rd_bank_d;
        end
    end

    assign full    = full_q;
    assign rd_data = rd_bank_q ? q1 : q0;
endmodule

// File: rtl/sd_block_streamer.sv
// sd_block_streamer: sequences sd_card through consecutive block reads into a
// ping-pong buffer and streams the bytes out over valid/ready.
module sd_block_streamer
    import sd_block_streamer_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_blk,
    input  logic [CNT_W-1:0]  num_blks,
    input  logic              stop,
    input  logic              sd_init_finished,
    output logic              sd_rd_req,
    output logic [ADDR_W-1:0] sd_block_addr,
    input  logic [7:0]        sd_dout,
    input  logic              sd_valid,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [ADDR_W-1:0] out_blk,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  blk_cnt
);
    fill_state_t       state_q, state_d;
    logic              fill_bank_q, fill_bank_d;
    logic [9:0]        fill_cnt_q, fill_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  num_q, num_d;
    logic [CNT_W-1:0]  issued_q, issued_d;
    logic              stop_seen_q, stop_seen_d;
    logic              done_q, done_d;

    logic              iss_bank_q, iss_bank_d;
    logic [IDX_W-1:0]  iss_idx_q, iss_idx_d;
    logic              infl_q, infl_d;
    logic              infl_last_q, infl_last_d;
    logic              infl_bank_q, infl_bank_d;
    skid_ent_t         ent0_q, ent0_d, ent1_q, ent1_d;
    logic [1:0]        occ_q, occ_d;
    logic [ADDR_W-1:0] out_blk_q, out_blk_d;
    logic [CNT_W-1:0]  blk_cnt_q, blk_cnt_d;

    logic              start_ok, wr_en, set_full, discard;
    logic              pop, last_pop, issue;
    logic [1:0]        full, occ_after_pop, resv;
    logic [7:0]        rd_data;
    skid_ent_t         new_ent;

    assign start_ok      = start && state_q == S_IDLE && !done_q;
    assign busy          = state_q != S_IDLE || done_q;
    assign done          = done_q;
    assign sd_rd_req     = state_q == S_REQ;
    assign sd_block_addr = addr_q;
    assign out_valid     = occ_q != 2'd0;
    assign out_data      = ent0_q.data;
    assign out_last      = ent0_q.last;
    assign out_blk       = out_blk_q;
    assign blk_cnt       = blk_cnt_q;

    always_comb begin
        state_d     = state_q;
        fill_bank_d = fill_bank_q;
        fill_cnt_d  = fill_cnt_q;
        addr_d      = addr_q;
        num_d       = num_q;
        issued_d    = issued_q;
        done_d      = 1'b0;
        wr_en       = 1'b0;
        set_full    = 1'b0;
        discard     = stop_seen_q || stop;
        stop_seen_d = stop_seen_q || (stop && state_q != S_IDLE && state_q != S_FLUSH);
        case (state_q)
            S_IDLE: if (start_ok) begin
                state_d     = S_WAIT_INIT;
                addr_d      = start_blk;
                num_d       = num_blks;
                issued_d    = '0;
                stop_seen_d = 1'b0;
                fill_bank_d = 1'b0;
            end
            S_WAIT_INIT: state_d = stop_seen_q ? S_FLUSH : (sd_init_finished ? S_REQ : S_WAIT_INIT);
            S_REQ: begin
                fill_cnt_d = '0;
                state_d    = S_FILL;
            end
            S_FILL: if (sd_valid) begin
                wr_en      = 1'b1;
                fill_cnt_d = fill_cnt_q + 10'd1;
                // A block in flight always completes; a pending stop only drops its data.
                if (fill_cnt_q == 10'(BLK_BYTES - 1)) begin
                    set_full    = !discard;
                    fill_bank_d = !fill_bank_q;
                    addr_d      = addr_q + ADDR_W'(1);
                    issued_d    = issued_q + CNT_W'(1);
                    state_d     = discard ? S_FLUSH : S_NEXT;
                end
            end
            S_NEXT: begin
                if (stop_seen_q || stop || (num_q != '0 && issued_q == num_q)) state_d = S_FLUSH;
                else if (!full[fill_bank_q])                                   state_d = S_REQ;
            end
            S_FLUSH: if (full == 2'b00) begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign pop           = out_valid && out_ready;
    assign last_pop      = pop && ent0_q.last;
    assign occ_after_pop = occ_q - {1'b0, pop};
    assign resv          = occ_after_pop + {1'b0, infl_q};
    // Issue a read only if the skid will still have room when its data lands.
    assign issue         = full[iss_bank_q] && resv < 2'd2;
    assign new_ent       = {infl_bank_q, infl_last_q, rd_data};

    always_comb begin
        iss_bank_d  = iss_bank_q;
        iss_idx_d   = iss_idx_q;
        infl_d      = issue;
        infl_last_d = &iss_idx_q;
        infl_bank_d = iss_bank_q;
        ent0_d      = pop ? ent1_q : ent0_q;
        ent1_d      = ent1_q;
        occ_d       = resv;
        out_blk_d   = out_blk_q + ADDR_W'(last_pop);
        blk_cnt_d   = blk_cnt_q + CNT_W'(last_pop);
        if (infl_q) begin
            if (occ_after_pop[0]) ent1_d = new_ent;
            else                  ent0_d = new_ent;
        end
        if (issue) begin
            iss_idx_d = iss_idx_q + IDX_W'(1);
            if (&iss_idx_q) iss_bank_d = !iss_bank_q;
        end
        if (start_ok) begin
            iss_bank_d = 1'b0;
            iss_idx_d  = '0;
            out_blk_d  = start_blk;
            blk_cnt_d  = '0;
        end
    end

    sd_pingpong_buf u_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_en),
        .wr_bank (fill_bank_q),
        .wr_idx  (fill_cnt_q[IDX_W-1:0]),
        .wr_data (sd_dout),
        .set_full(set_full),
        .set_bank(fill_bank_q),
        .clr_full(last_pop),
        .clr_bank(ent0_q.bank),
        .rd_en   (issue),
        .rd_bank (iss_bank_q),
        .rd_idx  (iss_idx_q),
        .rd_data (rd_data),
        .full    (full)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            fill_bank_q <= 1'b0;
            fill_cnt_q  <= '0;
            addr_q      <= '0;
            num_q       <= '0;
            issued_q    <= '0;
            stop_seen_q <= 1'b0;
            done_q      <= 1'b0;
            iss_bank_q  <= 1'b0;
            iss_idx_q   <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            infl_bank_q <= 1'b0;
            ent0_q      <= '0;
            ent1_q      <= '0;
            occ_q       <= '0;
            out_blk_q   <= '0;
            blk_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            fill_bank_q <= fill_bank_d;
            fill_cnt_q  <= fill_cnt_d;
            addr_q      <= addr_d;
            num_q       <= num_d;
            issued_q    <= issued_d;
            stop_seen_q <= stop_seen_d;
            done_q      <= done_d;
            iss_bank_q  <= iss_bank_d;
            iss_idx_q   <= iss_idx_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
            infl_bank_q <= infl_bank_d;
            ent0_q      <= ent0_d;
            ent1_q      <= ent1_d;
            occ_q       <= occ_d;
            out_blk_q   <= out_blk_d;
            blk_cnt_q   <= blk_cnt_d;
        end
    end
endmodule
